// File: rtl/traffic_lamp_monitor_pkg.sv
// Shared types and helpers for the traffic lamp conflict monitor.
package traffic_lamp_monitor_pkg;

  // Decoded state of one street's lamp triple.
  typedef enum logic [1:0] {
    PH_UNK = 2'd0,
    PH_RED = 2'd1,
    PH_GRN = 2'd2,
    PH_YLW = 2'd3
  } phase_e;

  typedef logic [2:0] fault_code_t;

  localparam fault_code_t FC_NONE      = 3'd0;
  localparam fault_code_t FC_CONFLICT  = 3'd1;
  localparam fault_code_t FC_INVALID   = 3'd2;
  localparam fault_code_t FC_ILLEGAL   = 3'd3;
  localparam fault_code_t FC_SHORT_YLW = 3'd4;

  typedef struct packed {
    logic   valid;
    phase_e phase;
  } lamp_dec_t;

  // Exactly one lamp lit gives a valid phase; anything else is invalid.
  function automatic lamp_dec_t decode_lamps(input logic grn, input logic ylw, input logic red);
    lamp_dec_t dec;
    dec = '{valid: 1'b0, phase: PH_UNK};
    case ({grn, ylw, red})
      3'b100:  dec = '{valid: 1'b1, phase: PH_GRN};
      3'b010:  dec = '{valid: 1'b1, phase: PH_YLW};
      3'b001:  dec = '{valid: 1'b1, phase: PH_RED};
      default: dec = '{valid: 1'b0, phase: PH_UNK};
    endcase
    return dec;
  endfunction

  // Forward steps of the normal cycle; self-loops are handled by the caller.
  function automatic logic is_legal_step(input phase_e cur, input phase_e nxt);
    return (cur == PH_RED && nxt == PH_GRN) ||
           (cur == PH_GRN && nxt == PH_YLW) ||
           (cur == PH_YLW && nxt == PH_RED);
  endfunction

endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// Lamp drives from the controller and fault/phase reporting back to it.
interface traffic_lamp_monitor_if;
  import traffic_lamp_monitor_pkg::*;

  logic        pgrn1, pylw1, pred1;
  logic        pgrn2, pylw2, pred2;
  logic        pfm;
  logic        pfault;
  fault_code_t fault_code;
  logic        fault_chan;
  phase_e      phase1, phase2;

  // Controller side: drives lamps, receives the flash request and status.
  modport master (
    output pgrn1, pylw1, pred1, pgrn2, pylw2, pred2,
    input  pfm, pfault, fault_code, fault_chan, phase1, phase2
  );

  // Monitor side.
  modport slave (
    input  pgrn1, pylw1, pred1, pgrn2, pylw2, pred2,
    output pfm, pfault, fault_code, fault_chan, phase1, phase2
  );
endinterface

// File: rtl/traffic_lamp_monitor_lamp_channel_check.sv
// Per-street phase tracker: follows the lamps and flags invalid patterns,
// illegal phase steps and yellows released to red too early.
module lamp_channel_check
  import traffic_lamp_monitor_pkg::*;
#(
  parameter int MIN_YLW = 3,
  parameter int DEB     = 2
) (
  input  logic   clock,
  input  logic   pclr,
  input  logic   grn,
  input  logic   ylw,
  input  logic   red,
  output phase_e phase,
  output logic   invalid_fault,
  output logic   illegal_fault,
  output logic   short_ylw_fault
);

  localparam int DW = $clog2(MIN_YLW + 1);
  localparam int IW = $clog2(DEB + 1);

  phase_e        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d, dwell_inc;
  logic [IW-1:0] inv_cnt_q, inv_cnt_d;
  lamp_dec_t     dec;

  // Next state, counters and fault flags from the registered lamp triple.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    dec             = decode_lamps(grn, ylw, red);
    state_d         = state_q;
    dwell_d         = dwell_q;
    inv_cnt_d       = inv_cnt_q;
    invalid_fault   = 1'b0;
    illegal_fault   = 1'b0;
    short_ylw_fault = 1'b0;
    // The current cycle counts toward the yellow dwell, so compare the bumped value.
    dwell_inc       = (dwell_q == DW'(MIN_YLW)) ? dwell_q : dwell_q + DW'(1);

    if (!dec.valid) begin
      // Hold the phase; a glitch must persist DEB cycles before it is a fault.
      inv_cnt_d     = (inv_cnt_q == IW'(DEB)) ? inv_cnt_q : inv_cnt_q + IW'(1);
      invalid_fault = (inv_cnt_d == IW'(DEB));
      if (state_q == PH_YLW) dwell_d = dwell_inc;
    end else begin
      inv_cnt_d = '0;
      state_d   = dec.phase;
      if (state_q != PH_UNK && dec.phase != state_q && !is_legal_step(state_q, dec.phase))
        illegal_fault = 1'b1;
      if (state_q == PH_YLW && dec.phase == PH_RED && dwell_inc < DW'(MIN_YLW))
        short_ylw_fault = 1'b1;
      if (dec.phase == PH_YLW) dwell_d = (state_q == PH_YLW) ? dwell_inc : '0;
      else                     dwell_d = '0;
    end
  end

  // Channel state register with synchronous clear.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (pclr) begin
      state_q   <= PH_UNK;
      dwell_q   <= '0;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign phase = state_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Lamp conflict monitor: registers the lamp drives, runs per-street checks
// plus the cross-street conflict check, and latches the first fault.
module traffic_lamp_monitor
  import traffic_lamp_monitor_pkg::*;
#(
  parameter int MIN_YLW = 3,
  parameter int DEB     = 2
) (
  input logic                   clock,
  input logic                   pclr,
  traffic_lamp_monitor_if.slave lamp_bus
);

  logic [2:0]  lamp1_q, lamp1_d, lamp2_q, lamp2_d;   // {grn, ylw, red}
  phase_e      phase1, phase2;
  logic        inv1, inv2, ill1, ill2, shy1, shy2, conflict;
  fault_code_t code_sel;
  logic        chan_sel;
  logic        pfault_q, pfault_d, pfm_q, pfm_d, fault_chan_q, fault_chan_d;
  fault_code_t fault_code_q, fault_code_d;

  // Stage 1 capture of the raw lamp drives.
  always_comb begin
    lamp1_d = {lamp_bus.pgrn1, lamp_bus.pylw1, lamp_bus.pred1};
    lamp2_d = {lamp_bus.pgrn2, lamp_bus.pylw2, lamp_bus.pred2};
  end

  // Input registers, cleared so a restart begins from an all-dark sample.
  always_ff @(posedge clock) begin
    if (pclr) begin
      lamp1_q <= '0;
      lamp2_q <= '0;
    end else begin
      lamp1_q <= lamp1_d;
      lamp2_q <= lamp2_d;
    end
  end

  lamp_channel_check #(.MIN_YLW(MIN_YLW), .DEB(DEB)) u_chan1 (
    .clock(clock), .pclr(pclr),
    .grn(lamp1_q[2]), .ylw(lamp1_q[1]), .red(lamp1_q[0]),
    .phase(phase1), .invalid_fault(inv1), .illegal_fault(ill1), .short_ylw_fault(shy1)
  );

  lamp_channel_check #(.MIN_YLW(MIN_YLW), .DEB(DEB)) u_chan2 (
    .clock(clock), .pclr(pclr),
    .grn(lamp2_q[2]), .ylw(lamp2_q[1]), .red(lamp2_q[0]),
    .phase(phase2), .invalid_fault(inv2), .illegal_fault(ill2), .short_ylw_fault(shy2)
  );

  // Any green-or-yellow on both streets at once is a conflict, regardless of validity.
  assign conflict = (lamp1_q[2] | lamp1_q[1]) & (lamp2_q[2] | lamp2_q[1]);

  // Priority encode this cycle's faults and decide whether the latch takes one.
  always_comb begin
    code_sel     = FC_NONE;
    chan_sel     = 1'b0;
    if      (conflict) code_sel = FC_CONFLICT;
    else if (inv1)      code_sel = FC_INVALID;
    else if (inv2)    begin code_sel = FC_INVALID;   chan_sel = 1'b1; end
    else if (ill1)      code_sel = FC_ILLEGAL;
    else if (ill2)    begin code_sel = FC_ILLEGAL;   chan_sel = 1'b1; end
    else if (shy1)      code_sel = FC_SHORT_YLW;
    else if (shy2)    begin code_sel = FC_SHORT_YLW; chan_sel = 1'b1; end

    pfault_d     = pfault_q;
    fault_code_d = fault_code_q;
    fault_chan_d = fault_chan_q;
    pfm_d        = 1'b0;
    // Only the first fault is recorded; later ones neither pulse nor overwrite.
    if (!pfault_q && code_sel != FC_NONE) begin
      pfault_d     = 1'b1;
      fault_code_d = code_sel;
      fault_chan_d = chan_sel;
      pfm_d        = 1'b1;
    end
  end

  // Fault latch; clear wins over a fault found in the same cycle.
  always_ff @(posedge clock) begin
    if (pclr) begin
      pfault_q     <= 1'b0;
      fault_code_q <= FC_NONE;
      fault_chan_q <= 1'b0;
      pfm_q        <= 1'b0;
    end else begin
      pfault_q     <= pfault_d;
      fault_code_q <= fault_code_d;
      fault_chan_q <= fault_chan_d;
      pfm_q        <= pfm_d;
    end
  end

  assign lamp_bus.pfm        = pfm_q;
  assign lamp_bus.pfault     = pfault_q;
  assign lamp_bus.fault_code = fault_code_q;
  assign lamp_bus.fault_chan = fault_chan_q;
  assign lamp_bus.phase1     = phase1;
  assign lamp_bus.phase2     = phase2;

endmodule
